// File: rtl/miniRISC_pkg.sv
// Shared constants and types for the KGP-miniRISC multi-cycle control unit.
// Holds opcode/func encodings, FSM state enum, select encodings and ALUop values.
package miniRISC_pkg;

    localparam int OPC_W_P   = 6;
    localparam int FUNC_W_P  = 5;
    localparam int ALUOP_W_P = 5;

    // Opcodes
    localparam logic [OPC_W_P-1:0] OP_RTYPE  = 6'd0;
    localparam logic [OPC_W_P-1:0] OP_ADDI   = 6'd1;
    localparam logic [OPC_W_P-1:0] OP_COMPI  = 6'd2;
    localparam logic [OPC_W_P-1:0] OP_LW     = 6'd3;
    localparam logic [OPC_W_P-1:0] OP_SW     = 6'd4;
    localparam logic [OPC_W_P-1:0] OP_BRANCH = 6'd5;
    localparam logic [OPC_W_P-1:0] OP_HALT   = 6'd63;

    // R-type func ranges
    localparam logic [FUNC_W_P-1:0] FR_SHIFT_LO = 5'd4;
    localparam logic [FUNC_W_P-1:0] FR_SHIFT_HI = 5'd9;
    localparam logic [FUNC_W_P-1:0] FR_MAX      = 5'd10;

    // Branch group func codes
    localparam logic [FUNC_W_P-1:0] FB_B    = 5'd0;
    localparam logic [FUNC_W_P-1:0] FB_BR   = 5'd1;
    localparam logic [FUNC_W_P-1:0] FB_BLTZ = 5'd2;
    localparam logic [FUNC_W_P-1:0] FB_BZ   = 5'd3;
    localparam logic [FUNC_W_P-1:0] FB_BNZ  = 5'd4;
    localparam logic [FUNC_W_P-1:0] FB_BL   = 5'd5;
    localparam logic [FUNC_W_P-1:0] FB_BCY  = 5'd6;
    localparam logic [FUNC_W_P-1:0] FB_BNCY = 5'd7;

    // regDst / memToReg selects
    localparam logic [1:0] RD_RT   = 2'd0;
    localparam logic [1:0] RD_RD   = 2'd1;
    localparam logic [1:0] RD_LINK = 2'd2;
    localparam logic [1:0] M2R_ALU = 2'd0;
    localparam logic [1:0] M2R_MEM = 2'd1;
    localparam logic [1:0] M2R_PC1 = 2'd2;

    // ALUop values used by non-R-type instructions
    localparam logic [ALUOP_W_P-1:0] ALU_NOP  = 5'd0;
    localparam logic [ALUOP_W_P-1:0] ALU_ADD  = 5'd1;
    localparam logic [ALUOP_W_P-1:0] ALU_COMP = 5'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_R,
        C_IMM,
        C_LW,
        C_SW,
        C_BR,
        C_HALT
    } iclass_t;

    typedef struct packed {
        iclass_t                cls;
        logic                   illegal;
        logic [ALUOP_W_P-1:0]   aluop;
        logic                   alusrc;
        logic                   alusel;
        logic                   lblsel;
        logic                   baddrsel;
        logic                   is_bl;
        logic [1:0]             regdst;
        logic [1:0]             memtoreg;
    } dec_t;

endpackage

// File: rtl/multicycle_control_fsm_ctrl_decode.sv
// Pure combinational opcode/func decoder: instruction class and static controls.
// Ports: i_opcode, i_func in; o_dec (dec_t bundle) out.
module ctrl_decode
    import miniRISC_pkg::*;
(
    input  logic [OPC_W_P-1:0]  i_opcode,
    input  logic [FUNC_W_P-1:0] i_func,
    output dec_t                o_dec
);

    always_comb begin
        o_dec     = '0;
        o_dec.cls = C_NOP;
        case (i_opcode)
            OP_RTYPE: begin
                if (i_func <= FR_MAX) begin
                    o_dec.cls      = C_R;
                    o_dec.aluop    = ALUOP_W_P'(i_func) + ALUOP_W_P'(1);
                    o_dec.alusel   = (i_func >= FR_SHIFT_LO) &&
                                     (i_func <= FR_SHIFT_HI);
                    o_dec.regdst   = RD_RD;
                    o_dec.memtoreg = M2R_ALU;
                end else begin
                    o_dec.illegal  = 1'b1;
                end
            end
            OP_ADDI: begin
                o_dec.cls    = C_IMM;
                o_dec.aluop  = ALU_ADD;
                o_dec.alusrc = 1'b1;
            end
            OP_COMPI: begin
                o_dec.cls    = C_IMM;
                o_dec.aluop  = ALU_COMP;
                o_dec.alusrc = 1'b1;
            end
            OP_LW: begin
                o_dec.cls      = C_LW;
                o_dec.aluop    = ALU_ADD;
                o_dec.alusrc   = 1'b1;
                o_dec.memtoreg = M2R_MEM;
            end
            OP_SW: begin
                o_dec.cls    = C_SW;
                o_dec.aluop  = ALU_ADD;
                o_dec.alusrc = 1'b1;
            end
            OP_BRANCH: begin
                if (i_func <= FB_BNCY) begin
                    o_dec.cls      = C_BR;
                    o_dec.lblsel   = (i_func == FB_BLTZ) ||
                                     (i_func == FB_BZ)   ||
                                     (i_func == FB_BNZ)  ||
                                     (i_func == FB_BCY)  ||
                                     (i_func == FB_BNCY);
                    o_dec.baddrsel = (i_func == FB_BR);
                    o_dec.is_bl    = (i_func == FB_BL);
                    o_dec.regdst   = RD_LINK;
                    o_dec.memtoreg = M2R_PC1;
                end else begin
                    o_dec.illegal  = 1'b1;
                end
            end
            OP_HALT: begin
                o_dec.cls = C_HALT;
            end
            default: begin
                o_dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM for KGP-miniRISC: FETCH/DECODE/EXEC/MEM/WB sequencing
// with single-cycle write strobes and mem_ready stretching of FETCH and MEM.
// Ports: clk, rst (sync, active-high), opcode, func, mem_ready in;
// datapath controls (pcWrite..branchAddrSel) and halted out.
// Build option: ILLEGAL_TRAP_EN sends illegal encodings to HALT instead of NOP.
module multicycle_control_fsm
    import miniRISC_pkg::*;
#(
    parameter int OPC_W   = OPC_W_P,
    parameter int FUNC_W  = FUNC_W_P,
    parameter int ALUOP_W = ALUOP_W_P
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [FUNC_W-1:0]  func,
    input  logic               mem_ready,
    output logic               pcWrite,
    output logic               irWrite,
    output logic [1:0]         regDst,
    output logic               regWrite,
    output logic [1:0]         memToReg,
    output logic               memRead,
    output logic               memWrite,
    output logic               ALUsrc,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               ALUsel,
    output logic               isBranch,
    output logic               lblSel,
    output logic               branchAddrSel,
    output logic               halted
);

    state_t            r_state;
    state_t            w_next;
    logic [OPC_W-1:0]  r_opcode;
    logic [FUNC_W-1:0] r_func;
    logic [OPC_W-1:0]  w_op;
    logic [FUNC_W-1:0] w_fn;
    dec_t              w_dec;

    // DECODE steers on the live fields; later states use the latched copy.
    assign w_op = (r_state == S_DECODE) ? opcode : r_opcode;
    assign w_fn = (r_state == S_DECODE) ? func   : r_func;

    ctrl_decode u_dec (
        .i_opcode (w_op),
        .i_func   (w_fn),
        .o_dec    (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_func   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_opcode <= opcode;
                r_func   <= func;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        pcWrite       = 1'b0;
        irWrite       = 1'b0;
        regDst        = RD_RT;
        regWrite      = 1'b0;
        memToReg      = M2R_ALU;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        ALUsrc        = 1'b0;
        ALUop         = '0;
        ALUsel        = 1'b0;
        isBranch      = 1'b0;
        lblSel        = 1'b0;
        branchAddrSel = 1'b0;
        halted        = 1'b0;

        // ALU controls stay valid for the whole EXEC/MEM/WB span.
        if ((r_state == S_EXEC) || (r_state == S_MEM) ||
            (r_state == S_WB)) begin
            ALUsrc = w_dec.alusrc;
            ALUop  = w_dec.aluop;
            ALUsel = w_dec.alusel;
        end

        unique case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                memRead = 1'b1;
                irWrite = 1'b1;
                if (mem_ready) begin
                    pcWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec.cls == C_HALT) begin
                    w_next = S_HALT;
                end else if (w_dec.illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = S_HALT;
`else
                    w_next = S_FETCH;
`endif
                end else if (w_dec.cls == C_NOP) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_dec.cls == C_BR) begin
                    isBranch      = 1'b1;
                    lblSel        = w_dec.lblsel;
                    branchAddrSel = w_dec.baddrsel;
                    w_next        = w_dec.is_bl ? S_WB : S_FETCH;
                end else if ((w_dec.cls == C_LW) ||
                             (w_dec.cls == C_SW)) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                memRead  = (w_dec.cls == C_LW);
                memWrite = (w_dec.cls == C_SW);
                if (mem_ready) begin
                    w_next = (w_dec.cls == C_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                regDst   = w_dec.regdst;
                memToReg = w_dec.memtoreg;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Per-cycle expected outputs checked at negedge.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic       pc;
    logic       ir;
    logic [1:0] rd;
    logic       rw;
    logic [1:0] m2r;
    logic       mr;
    logic       mw;
    logic       src;
    logic [4:0] aop;
    logic       sel;
    logic       br;
    logic       lbl;
    logic       bas;
    logic       h;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [4:0] func = '0;
  logic       mem_ready = 1'b0;
  logic       pcWrite, irWrite, regWrite;
  logic       memRead, memWrite;
  logic       ALUsrc, ALUsel, isBranch;
  logic       lblSel, branchAddrSel, halted;
  logic [1:0] regDst, memToReg;
  logic [4:0] ALUop;

  int errors = 0;
  int checks = 0;
  outs_t q[$];
  string nq[$];
  logic [5:0] cur_op;
  logic [4:0] cur_fn;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst),
    .opcode(opcode), .func(func),
    .mem_ready(mem_ready),
    .pcWrite(pcWrite), .irWrite(irWrite),
    .regDst(regDst), .regWrite(regWrite),
    .memToReg(memToReg),
    .memRead(memRead), .memWrite(memWrite),
    .ALUsrc(ALUsrc), .ALUop(ALUop),
    .ALUsel(ALUsel), .isBranch(isBranch),
    .lblSel(lblSel),
    .branchAddrSel(branchAddrSel),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(
    int pc, int ir, int rd, int rw, int m2r,
    int mr, int mw, int src, int aop, int sel,
    int br, int lbl, int bas, int h);
    outs_t e;
    e.pc  = 1'(pc);  e.ir  = 1'(ir);
    e.rd  = 2'(rd);  e.rw  = 1'(rw);
    e.m2r = 2'(m2r); e.mr  = 1'(mr);
    e.mw  = 1'(mw);  e.src = 1'(src);
    e.aop = 5'(aop); e.sel = 1'(sel);
    e.br  = 1'(br);  e.lbl = 1'(lbl);
    e.bas = 1'(bas); e.h   = 1'(h);
    return e;
  endfunction

  function automatic outs_t Z();
    return mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
  endfunction

  function automatic outs_t FT(int r);
    return mk(r,1,0,0,0,1,0,0,0,0,0,0,0,0);
  endfunction

  function automatic outs_t HL();
    return mk(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
  endfunction

  function automatic outs_t cur();
    outs_t a;
    a.pc = pcWrite;  a.ir = irWrite;
    a.rd = regDst;   a.rw = regWrite;
    a.m2r = memToReg; a.mr = memRead;
    a.mw = memWrite; a.src = ALUsrc;
    a.aop = ALUop;   a.sel = ALUsel;
    a.br = isBranch; a.lbl = lblSel;
    a.bas = branchAddrSel; a.h = halted;
    return a;
  endfunction

  task automatic cyc(input string n,
                     input outs_t e,
                     input logic r,
                     input logic d);
    opcode    = d ? cur_op : 6'd62;
    func      = d ? cur_fn : 5'd31;
    mem_ready = r;
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      outs_t e, a;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      a = cur();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %05h want %05h",
                 n, a, e);
      end
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout: stimulus did not finish");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    cur_op = 6'd0; cur_fn = 5'd0;
    @(posedge clk); #1;
    checks++;
    if (cur() !== Z()) begin
      errors++;
      $display("FAIL reset state: got %05h", cur());
    end
    cyc("rst0", Z(), 0, 0);
    cyc("rst1", Z(), 0, 0);
    rst = 1'b0;
    cyc("idle", Z(), 0, 0);

    cur_op = 6'd0; cur_fn = 5'd0;
    cyc("add_f", FT(1), 1, 0);
    cyc("add_d", Z(), 1, 1);
    cyc("add_x",
        mk(0,0,0,0,0,0,0,0,1,0,0,0,0,0), 1, 0);
    cyc("add_w",
        mk(0,0,1,1,0,0,0,0,1,0,0,0,0,0), 1, 0);

    cur_op = 6'd0; cur_fn = 5'd5;
    cyc("shf_f", FT(1), 1, 0);
    cyc("shf_d", Z(), 1, 1);
    cyc("shf_x",
        mk(0,0,0,0,0,0,0,0,6,1,0,0,0,0), 1, 0);
    cyc("shf_w",
        mk(0,0,1,1,0,0,0,0,6,1,0,0,0,0), 1, 0);

    cur_op = 6'd1; cur_fn = 5'd0;
    cyc("addi_f0", FT(0), 0, 0);
    cyc("addi_f1", FT(1), 1, 0);
    cyc("addi_d", Z(), 1, 1);
    cyc("addi_x",
        mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0), 1, 0);
    cyc("addi_w",
        mk(0,0,0,1,0,0,0,1,1,0,0,0,0,0), 1, 0);

    cur_op = 6'd3; cur_fn = 5'd0;
    cyc("lw_f", FT(1), 1, 0);
    cyc("lw_d", Z(), 0, 1);
    cyc("lw_x",
        mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0), 0, 0);
    cyc("lw_m0",
        mk(0,0,0,0,0,1,0,1,1,0,0,0,0,0), 0, 0);
    cyc("lw_m1",
        mk(0,0,0,0,0,1,0,1,1,0,0,0,0,0), 0, 0);
    cyc("lw_m2",
        mk(0,0,0,0,0,1,0,1,1,0,0,0,0,0), 1, 0);
    cyc("lw_w",
        mk(0,0,0,1,1,0,0,1,1,0,0,0,0,0), 1, 0);

    cur_op = 6'd4; cur_fn = 5'd0;
    cyc("sw_f", FT(1), 1, 0);
    cyc("sw_d", Z(), 1, 1);
    cyc("sw_x",
        mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0), 0, 0);
    cyc("sw_m0",
        mk(0,0,0,0,0,0,1,1,1,0,0,0,0,0), 0, 0);
    cyc("sw_m1",
        mk(0,0,0,0,0,0,1,1,1,0,0,0,0,0), 1, 0);

    cur_op = 6'd5; cur_fn = 5'd3;
    cyc("bz_f", FT(1), 1, 0);
    cyc("bz_d", Z(), 1, 1);
    cyc("bz_x",
        mk(0,0,0,0,0,0,0,0,0,0,1,1,0,0), 1, 0);

    cur_op = 6'd5; cur_fn = 5'd1;
    cyc("br_f", FT(1), 1, 0);
    cyc("br_d", Z(), 1, 1);
    cyc("br_x",
        mk(0,0,0,0,0,0,0,0,0,0,1,0,1,0), 1, 0);

    cur_op = 6'd5; cur_fn = 5'd5;
    cyc("bl_f", FT(1), 1, 0);
    cyc("bl_d", Z(), 1, 1);
    cyc("bl_x",
        mk(0,0,0,0,0,0,0,0,0,0,1,0,0,0), 1, 0);
    cyc("bl_w",
        mk(0,0,2,1,2,0,0,0,0,0,0,0,0,0), 1, 0);

    cur_op = 6'd4; cur_fn = 5'd0;
    cyc("swr_f", FT(1), 1, 0);
    cyc("swr_d", Z(), 1, 1);
    cyc("swr_x",
        mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0), 0, 0);
    rst = 1'b1;
    cyc("swr_m",
        mk(0,0,0,0,0,0,1,1,1,0,0,0,0,0), 0, 0);
    rst = 1'b0;
    cyc("swr_idle", Z(), 1, 0);

    cur_op = 6'd0; cur_fn = 5'd15;
    cyc("ill_f", FT(1), 1, 0);
    cyc("ill_d", Z(), 1, 1);
`ifdef ILLEGAL_TRAP_EN
    cyc("ill_h0", HL(), 1, 0);
    cyc("ill_h1", HL(), 1, 0);
    rst = 1'b1;
    cyc("ill_hr", HL(), 1, 0);
    rst = 1'b0;
    cyc("ill_idle", Z(), 1, 0);
`endif

    cur_op = 6'd63; cur_fn = 5'd0;
    cyc("hlt_f", FT(1), 1, 0);
    cyc("hlt_d", Z(), 1, 1);
    cyc("hlt_h0", HL(), 1, 0);
    cyc("hlt_h1", HL(), 0, 0);
    cyc("hlt_h2", HL(), 1, 0);
    rst = 1'b1;
    cyc("hlt_hr", HL(), 1, 0);
    rst = 1'b0;
    cyc("hlt_idle", Z(), 0, 0);
    cyc("post_f", FT(0), 0, 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
